// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register for the 8-bit ALU.
// Decodes opcode/funct3/funct7[5] into a 4-bit ALU control code, registers
// operands/immediate/destination, and applies EX/MEM and MEM/WB forwarding
// onto the operand buses on the output side.
module alu_issue_stage #(
    parameter int XLEN = 8,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_b5,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_regwrite,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] alu_data1,
    output logic [XLEN-1:0] alu_data2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            ex_illegal
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_t;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    // Decode results (combinational, only ever consumed by the stage register)
    logic    dec_legal;
    alu_op_t dec_ctrl;
    logic    dec_use_rs2;
    logic    dec_regwrite;
    logic    dec_memread;
    logic    dec_memwrite;
    logic    dec_branch;

    // Stage registers
    logic            valid_q;
    alu_op_t         ctrl_q;
    logic            use_rs2_q;
    logic            regwrite_q;
    logic            memread_q;
    logic            memwrite_q;
    logic            branch_q;
    logic            illegal_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [REGW-1:0] rd_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Decode opcode/funct fields into ALU control and class flags
    always_comb begin
        dec_legal    = 1'b0;
        dec_ctrl     = ALU_AND;
        dec_use_rs2  = 1'b0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec_use_rs2  = 1'b1;
                dec_regwrite = 1'b1;
                case (id_funct3)
                    3'b000: begin dec_legal = 1'b1; dec_ctrl = id_funct7_b5 ? ALU_SUB : ALU_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                dec_regwrite = 1'b1;
                case (id_funct3)
                    3'b000: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec_legal    = (id_funct3 == 3'b000);
                dec_ctrl     = ALU_ADD;
                dec_memread  = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_STORE: begin
                dec_legal    = (id_funct3 == 3'b000);
                dec_ctrl     = ALU_ADD;
                dec_memwrite = 1'b1;
            end
            OP_BRANCH: begin
                dec_legal   = (id_funct3 == 3'b000);
                dec_ctrl    = ALU_SUB;
                dec_use_rs2 = 1'b1;
                dec_branch  = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Stage register: rst > flush > stall > load; illegal or empty slots load a zeroed bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q    <= 1'b0;
            ctrl_q     <= ALU_AND;
            use_rs2_q  <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            illegal_q  <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (stall) begin
            illegal_q <= 1'b0;
        end else if (id_valid && dec_legal) begin
            valid_q    <= 1'b1;
            ctrl_q     <= dec_ctrl;
            use_rs2_q  <= dec_use_rs2;
            regwrite_q <= dec_regwrite;
            memread_q  <= dec_memread;
            memwrite_q <= dec_memwrite;
            branch_q   <= dec_branch;
            illegal_q  <= 1'b0;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= dec_regwrite ? id_rd : '0;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
        end else begin
            valid_q    <= 1'b0;
            ctrl_q     <= ALU_AND;
            use_rs2_q  <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            illegal_q  <= id_valid;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end
    end

    // Forwarding mux for one stored source index; EX/MEM beats MEM/WB, x0 never forwards
    function automatic logic [XLEN-1:0] forward(input logic [REGW-1:0] idx,
                                                input logic [XLEN-1:0] regval);
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idx))
            return exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idx))
            return memwb_result;
        else
            return regval;
    endfunction

    // Operand buses after forwarding
    always_comb begin
        fwd_rs1 = forward(rs1_q, rs1_data_q);
        fwd_rs2 = forward(rs2_q, rs2_data_q);
    end

    assign ex_valid      = valid_q;
    assign alu_control   = ctrl_q;
    assign alu_data1     = fwd_rs1;
    assign alu_data2     = use_rs2_q ? fwd_rs2 : imm_q;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;
    assign ex_branch     = branch_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [2:0] id_funct3;
    logic       id_funct7_b5;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [7:0] id_rs1_data, id_rs2_data, id_imm;
    logic       stall, flush;
    logic       exmem_regwrite;
    logic [4:0] exmem_rd;
    logic [7:0] exmem_result;
    logic       memwb_regwrite;
    logic [4:0] memwb_rd;
    logic [7:0] memwb_result;
    logic       ex_valid;
    logic [3:0] alu_control;
    logic [7:0] alu_data1, alu_data2, ex_store_data;
    logic [4:0] ex_rd;
    logic       ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.XLEN(8), .REGW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .stall(stall), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_control(alu_control),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                         input logic [4:0] r1, input logic [7:0] d1,
                         input logic [4:0] r2, input logic [7:0] d2,
                         input logic [4:0] rd, input logic [7:0] imm);
        id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_funct7_b5 = b5;
        id_rs1 = r1; id_rs1_data = d1; id_rs2 = r2; id_rs2_data = d2;
        id_rd = rd; id_imm = imm;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
        issue(7'b0110011, 3'b000, 1'b0, 5'd2, 8'h05, 5'd3, 8'h07, 5'd4, 8'h00);

        // Reset with a valid ADD on the inputs
        step();
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_ctrl", 32'(alu_control), 32'h0);
        chk("rst_rd", 32'(ex_rd), 32'h0);
        chk("rst_rw", 32'(ex_regwrite), 32'h0);
        chk("rst_ill", 32'(ex_illegal), 32'h0);
        chk("rst_d1", 32'(alu_data1), 32'h0);
        chk("rst_d2", 32'(alu_data2), 32'h0);

        // ADD
        rst = 1'b0;
        step();
        chk("add_valid", 32'(ex_valid), 32'h1);
        chk("add_ctrl", 32'(alu_control), 32'h2);
        chk("add_d1", 32'(alu_data1), 32'h05);
        chk("add_d2", 32'(alu_data2), 32'h07);
        chk("add_rd", 32'(ex_rd), 32'h4);
        chk("add_rw", 32'(ex_regwrite), 32'h1);

        // SUB
        issue(7'b0110011, 3'b000, 1'b1, 5'd2, 8'h20, 5'd3, 8'h08, 5'd6, 8'h00);
        step();
        chk("sub_ctrl", 32'(alu_control), 32'h6);
        chk("sub_rw", 32'(ex_regwrite), 32'h1);
        chk("sub_rd", 32'(ex_rd), 32'h6);
        chk("sub_d2", 32'(alu_data2), 32'h08);

        // BEQ
        issue(7'b1100011, 3'b000, 1'b0, 5'd1, 8'h11, 5'd2, 8'h11, 5'd9, 8'h40);
        step();
        chk("beq_ctrl", 32'(alu_control), 32'h6);
        chk("beq_branch", 32'(ex_branch), 32'h1);
        chk("beq_rd", 32'(ex_rd), 32'h0);
        chk("beq_rw", 32'(ex_regwrite), 32'h0);
        chk("beq_d2", 32'(alu_data2), 32'h11);

        // ORI
        issue(7'b0010011, 3'b110, 1'b0, 5'd1, 8'h0F, 5'd2, 8'h99, 5'd7, 8'hF0);
        step();
        chk("ori_ctrl", 32'(alu_control), 32'h1);
        chk("ori_d2", 32'(alu_data2), 32'hF0);
        chk("ori_rw", 32'(ex_regwrite), 32'h1);
        chk("ori_branch", 32'(ex_branch), 32'h0);

        // ANDI
        issue(7'b0010011, 3'b111, 1'b0, 5'd1, 8'h0F, 5'd2, 8'h99, 5'd7, 8'h3C);
        step();
        chk("andi_ctrl", 32'(alu_control), 32'h0);
        chk("andi_d2", 32'(alu_data2), 32'h3C);
        chk("andi_valid", 32'(ex_valid), 32'h1);

        // LOAD
        issue(7'b0000011, 3'b000, 1'b0, 5'd1, 8'h10, 5'd2, 8'h99, 5'd8, 8'h04);
        step();
        chk("ld_ctrl", 32'(alu_control), 32'h2);
        chk("ld_memread", 32'(ex_memread), 32'h1);
        chk("ld_rd", 32'(ex_rd), 32'h8);
        chk("ld_d2", 32'(alu_data2), 32'h04);

        // STORE
        issue(7'b0100011, 3'b000, 1'b0, 5'd1, 8'h10, 5'd9, 8'h77, 5'd12, 8'h08);
        step();
        chk("st_ctrl", 32'(alu_control), 32'h2);
        chk("st_memwrite", 32'(ex_memwrite), 32'h1);
        chk("st_memread", 32'(ex_memread), 32'h0);
        chk("st_rw", 32'(ex_regwrite), 32'h0);
        chk("st_rd", 32'(ex_rd), 32'h0);
        chk("st_sdata", 32'(ex_store_data), 32'h77);
        chk("st_d2", 32'(alu_data2), 32'h08);

        // Forwarding onto a held ADD rs1=5, rs2=6
        issue(7'b0110011, 3'b000, 1'b0, 5'd5, 8'h01, 5'd6, 8'h02, 5'd3, 8'h00);
        step();
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 8'hAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 8'h55;
        #1;
        chk("fwd_exmem_prio", 32'(alu_data1), 32'hAA);
        chk("fwd_nomatch_d2", 32'(alu_data2), 32'h02);
        exmem_rd = 5'd0;
        #1;
        chk("fwd_exmem_x0", 32'(alu_data1), 32'h55);
        exmem_rd = 5'd5; exmem_regwrite = 1'b0;
        #1;
        chk("fwd_exmem_norw", 32'(alu_data1), 32'h55);
        memwb_rd = 5'd6;
        #1;
        chk("fwd_memwb_d2", 32'(alu_data2), 32'h55);
        chk("fwd_memwb_sd", 32'(ex_store_data), 32'h55);
        chk("fwd_d1_regval", 32'(alu_data1), 32'h01);
        exmem_regwrite = 1'b0; exmem_rd = '0; memwb_regwrite = 1'b0; memwb_rd = '0;

        // Illegal opcode pulse
        issue(7'b1111111, 3'b000, 1'b0, 5'd1, 8'h01, 5'd2, 8'h02, 5'd5, 8'h00);
        step();
        chk("ill_pulse", 32'(ex_illegal), 32'h1);
        chk("ill_valid", 32'(ex_valid), 32'h0);
        chk("ill_rw", 32'(ex_regwrite), 32'h0);
        chk("ill_rd", 32'(ex_rd), 32'h0);
        id_valid = 1'b0;
        step();
        chk("ill_clear", 32'(ex_illegal), 32'h0);

        // Illegal R-type funct3
        issue(7'b0110011, 3'b001, 1'b0, 5'd1, 8'h01, 5'd2, 8'h02, 5'd5, 8'h00);
        step();
        chk("ill_r_pulse", 32'(ex_illegal), 32'h1);
        chk("ill_r_valid", 32'(ex_valid), 32'h0);

        // Stall for three cycles with changing id_* inputs
        issue(7'b0110011, 3'b000, 1'b0, 5'd2, 8'h05, 5'd3, 8'h07, 5'd4, 8'h00);
        step();
        stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i == 1)
                issue(7'b1111111, 3'b000, 1'b0, 5'd9, 8'hEE, 5'd8, 8'hDD, 5'd7, 8'h00);
            else
                issue(7'b0110011, 3'b000, 1'b1, 5'd6, 8'h30 + 8'(i), 5'd7, 8'h40, 5'd9, 8'h00);
            step();
            chk("stall_ctrl", 32'(alu_control), 32'h2);
            chk("stall_d1", 32'(alu_data1), 32'h05);
            chk("stall_d2", 32'(alu_data2), 32'h07);
            chk("stall_rd", 32'(ex_rd), 32'h4);
            chk("stall_valid", 32'(ex_valid), 32'h1);
            chk("stall_ill", 32'(ex_illegal), 32'h0);
        end

        // Stall and flush together
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'h0);
        chk("flush_ctrl", 32'(alu_control), 32'h0);
        chk("flush_rw", 32'(ex_regwrite), 32'h0);
        chk("flush_rd", 32'(ex_rd), 32'h0);
        flush = 1'b0; stall = 1'b0;

        // Reset while a live ADD is held, then bubbles
        issue(7'b0110011, 3'b000, 1'b0, 5'd2, 8'h05, 5'd3, 8'h07, 5'd4, 8'h00);
        step();
        chk("pre_rst_valid", 32'(ex_valid), 32'h1);
        rst = 1'b1;
        step();
        chk("mrst_valid", 32'(ex_valid), 32'h0);
        chk("mrst_ctrl", 32'(alu_control), 32'h0);
        chk("mrst_rd", 32'(ex_rd), 32'h0);
        chk("mrst_d1", 32'(alu_data1), 32'h0);
        chk("mrst_d2", 32'(alu_data2), 32'h0);
        rst = 1'b0; id_valid = 1'b0;
        step();
        chk("bub_valid", 32'(ex_valid), 32'h0);
        chk("bub_ctrl", 32'(alu_control), 32'h0);
        chk("bub_ill", 32'(ex_illegal), 32'h0);
        step();
        chk("bub2_valid", 32'(ex_valid), 32'h0);
        chk("bub2_rw", 32'(ex_regwrite), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX stage that feeds the 8-bit ALU: decodes opcode/funct3/funct7[5] into the 4-bit ALU control code and registers operands, immediate and destination.
- Forwards the EX/MEM and MEM/WB results onto the ALU operand buses.
- Accepts stall and flush from the hazard unit, and flags unsupported instructions.
- It is the producer side of the ALU control/operand interface.

Parameters:
- XLEN, 8, operand/result width
- REGW, 5, register index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage presents an instruction
- id_opcode  in  7  instruction [6:0]
- id_funct3  in  3  instruction [14:12]
- id_funct7_b5  in  1  instruction [30]
- id_rs1, id_rs2, id_rd  in  REGW each  register indices
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data
- id_imm  in  XLEN  sign-extended immediate, truncated to XLEN
- stall  in  1  hold the stage contents
- flush  in  1  kill the stage contents
- exmem_regwrite  in  1  EX/MEM will write rd
- exmem_rd  in  REGW  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM result
- memwb_regwrite  in  1  MEM/WB will write rd
- memwb_rd  in  REGW  MEM/WB destination
- memwb_result  in  XLEN  MEM/WB result
- ex_valid  out  1  stage holds a live instruction
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- alu_data1, alu_data2  out  XLEN each  ALU operands (after forwarding)
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_rd  out  REGW  destination index
- ex_regwrite  out  1  rd is written
- ex_memread, ex_memwrite, ex_branch  out  1 each  class flags
- ex_illegal  out  1  one-cycle pulse for an unsupported instruction

Behaviour:
- Reset: on a rising clk with rst=1, all registered outputs clear:
  - ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal = 0
  - alu_control = 0000
  - ex_rd = 0
  - stored rs1/rs2/imm registers = 0
- Reset mid-stream discards the held instruction.
- Update priority per edge: rst > flush > stall > load.
  - flush: same clears as reset; flush wins over a simultaneous stall.
  - stall (no flush): every register holds its value and ex_illegal is forced to 0.
  - load: capture the decode result when id_valid=1; when id_valid=0, load a bubble (all flags 0, alu_control 0000).
- Decode, captured at load:
  - R-type 0110011:
    - f3=000, b5=0: ADD; f3=000, b5=1: SUB
    - f3=111: AND; f3=110: OR
    - op2 = rs2; regwrite = 1
  - I-ALU 0010011: f3=000 ADD, 111 AND, 110 OR; op2 = imm; regwrite = 1.
  - Load 0000011, f3=000: ADD; op2 = imm; memread = 1; regwrite = 1.
  - Store 0100011, f3=000: ADD; op2 = imm; memwrite = 1; regwrite = 0.
  - Branch 1100011, f3=000 (BEQ): SUB; op2 = rs2; branch = 1; regwrite = 0. The downstream zero flag resolves the branch.
  - Any other opcode/funct combination is illegal: load a bubble and set ex_illegal = 1 for exactly one cycle.
- ex_rd is forced to 0 whenever ex_regwrite = 0.
- Forwarding (combinational on outputs, using the stored rs1/rs2 indices):
  - A source X is forwarded from EX/MEM when exmem_regwrite=1, exmem_rd != 0 and exmem_rd == X; the value is exmem_result.
  - Otherwise from MEM/WB under the same test, giving memwb_result.
  - Otherwise the stored register data is used.
  - EX/MEM has priority when both match.
  - alu_data1 = forwarded rs1.
  - alu_data2 = forwarded rs2 when op2 = rs2, else the stored imm.
  - ex_store_data = forwarded rs2 always.
  - Index 0 is never forwarded.
- Latency: one cycle from id_* to ex_*. No combinational path from id_* to any output.
- Widths: all data is XLEN bits; no arithmetic is performed here.

Test Plan:
- Reset then ADD (0110011, f3=000, b5=0, rs1=2 data 0x05, rs2=3 data 0x07, rd=4) -> next cycle:
  - ex_valid=1, alu_control=0010, alu_data1=0x05, alu_data2=0x07, ex_rd=4, ex_regwrite=1
- SUB/BEQ/ORI/ANDI/load/store each issued once:
  - SUB b5=1 -> 0110 with regwrite
  - BEQ -> 0110, ex_branch=1, ex_rd=0
  - ORI imm 0xF0 -> 0001, alu_data2=0xF0
  - store -> 0010, ex_memwrite=1, ex_store_data=rs2 data
- Forwarding: stage holds rs1=5; exmem_regwrite=1, exmem_rd=5, result 0xAA and memwb also rd=5, result 0x55 -> alu_data1=0xAA. With exmem_rd=0 -> alu_data1=0x55.
- Illegal opcode 1111111 with id_valid=1 -> ex_illegal=1 for one cycle, ex_valid=0, ex_regwrite=0. Next cycle ex_illegal=0.
- Stall held 3 cycles with changing id_* -> outputs frozen. Stall+flush together -> ex_valid=0, alu_control=0000.
- rst asserted while a live ADD is held -> next edge all outputs at reset values. Deassert, then id_valid=0 -> bubble persists.
